sound_mix_sched: RTL

- Shares the single 1-bit PWM sound output among NCH one-bit sound sources: beeper, tape-out and timer channels.
- Once per sample period a scheduler FSM snapshots all sources and scans them one per clock.
- Each enabled, high source contributes its per-channel volume to a sum. The sum is saturated to 8 bits and loaded into a first-order sigma-delta PWM engine.
- Per-channel enable/volume registers are written through a simple config port. Sits between the source generators and the board audio pin.

---
 rtl/sound_mix_sched_pkg.sv | 13 +
 rtl/sound_mix_sched_pwm_sd1.sv | 24 ++
 rtl/sound_mix_sched.sv | 88 ++++++++
 3 files changed

// File: rtl/sound_mix_sched_pkg.sv
// sound_pkg: shared constants, FSM states and saturation helper for the sound mixer
package sound_pkg;
  localparam int NCH_DEF = 4;
  localparam int VOL_W_DEF = 4;
  localparam int SAMPLE_W = 8;
  localparam int VOL_SHIFT = 4;
  localparam int EN_BIT = VOL_W_DEF;
  localparam int VOL_RST = 8;
  typedef enum logic [1:0] {IDLE, SCAN, LOAD} state_t;
  function automatic logic [SAMPLE_W-1:0] sat8(input logic [31:0] s);
    return (s > 32'd255) ? 8'hFF : s[7:0];
  endfunction
endpackage

// File: rtl/sound_mix_sched_pwm_sd1.sv
// pwm_sd1: first-order sigma-delta modulator updated every other clock, with mute hold
module pwm_sd1
  import sound_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mute,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                o_pwm
);
  logic       phase;
  logic [8:0] acc;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase <= 1'b0;
      acc   <= '0;
      o_pwm <= 1'b0;
    end else begin
      phase <= ~phase;
      acc   <= mute ? '0 : !phase ? 9'(acc[7:0]) + 9'(sample) : acc;
      o_pwm <= !mute && acc[8];
    end
  end
endmodule

// File: rtl/sound_mix_sched.sv
// sound_mix_sched: scans NCH one-bit sources once per sample period and mixes them into a PWM output
module sound_mix_sched
  import sound_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int DIV   = 64,
  parameter int VOL_W = VOL_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NCH-1:0]          ch_pulse,
  input  logic                    mute,
  input  logic                    cfg_we,
  input  logic [$clog2(NCH)-1:0]  cfg_addr,
  input  logic [VOL_W:0]          cfg_wdata,
  output logic [SAMPLE_W-1:0]     sample,
  output logic                    sample_stb,
  output logic                    busy,
  output logic                    o_pwm
);
  localparam int AW = $clog2(NCH);
  localparam int CW = $clog2(DIV);
  localparam int SW = VOL_W + VOL_SHIFT + AW + 1;
  logic [CW-1:0]    cnt;
  logic             tick;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   snap;
  logic [VOL_W-1:0] vol [NCH];
  logic [AW-1:0]    idx;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    add;
  state_t           state;
  assign tick = cnt == CW'(DIV - 1);
  assign add = (en[idx] && snap[idx]) ? SW'(vol[idx]) << VOL_SHIFT : '0;
  always_ff @(posedge clk) begin
    cnt <= (!reset_n || tick) ? '0 : cnt + CW'(1);
  end
  // a write landing in a channel's visit cycle is seen only from the next scan
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en <= '1;
      for (int i = 0; i < NCH; i++) vol[i] <= VOL_W'(VOL_RST);
    end else if (cfg_we && 32'(cfg_addr) < NCH) begin
      {en[cfg_addr], vol[cfg_addr]} <= cfg_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      snap       <= '0;
      sum        <= '0;
      idx        <= '0;
      sample     <= '0;
      sample_stb <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          snap  <= ch_pulse;
          sum   <= '0;
          idx   <= '0;
          busy  <= 1'b1;
          state <= SCAN;
        end
        SCAN: begin
          sum <= sum + add;
          idx <= idx + AW'(1);
          if (idx == AW'(NCH - 1)) state <= LOAD;
        end
        LOAD: begin
          sample     <= sat8(32'(sum));
          sample_stb <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  pwm_sd1 u_pwm (
    .clk    (clk),
    .reset_n(reset_n),
    .mute   (mute),
    .sample (sample),
    .o_pwm  (o_pwm)
  );
endmodule
